// File: rtl/serial_pkg.sv
// Shared constants and types for the serial transmitter/receiver pair.
package serial_pkg;

  localparam int FRAME_BITS = 8;

  localparam logic START_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    DATA = 1'b1
  } rx_state_t;

endpackage

// File: rtl/serial_rx_holdreg.sv
// Output holding register for serial_rx: PDout/Valid, plus Ack/Overrun
// handshaking when SERIAL_RX_HANDSHAKE_EN is defined.
module serial_rx_holdreg #(
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
`ifdef SERIAL_RX_HANDSHAKE_EN
  input  logic              Ack,
  output logic              Overrun,
`endif
  output logic [DATA_W-1:0] PDout,
  output logic              Valid
);

`ifdef SERIAL_RX_HANDSHAKE_EN
  // A completed word is only accepted if the slot is free or being acked on
  // this very edge; otherwise it is dropped and the loss is remembered.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      PDout   <= '0;
      Valid   <= 1'b0;
      Overrun <= 1'b0;
    end else if (load && (!Valid || Ack)) begin
      PDout <= word;
      Valid <= 1'b1;
    end else if (load) begin
      Overrun <= 1'b1;
    end else if (Valid && Ack) begin
      Valid <= 1'b0;
    end
  end
`else
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      PDout <= '0;
      Valid <= 1'b0;
    end else begin
      Valid <= load;
      if (load) PDout <= word;
    end
  end
`endif

endmodule

// File: rtl/serial_rx.sv
// Serial-to-parallel receiver clocked by the transmitter's forwarded clock.
// Define SERIAL_RX_HANDSHAKE_EN for level Valid with Ack/Overrun.
module serial_rx
  import serial_pkg::*;
#(
  parameter int DATA_W = FRAME_BITS
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              SDin,
  output logic [DATA_W-1:0] PDout,
  output logic              Valid,
  output logic              Busy
`ifdef SERIAL_RX_HANDSHAKE_EN
  ,
  input  logic              Ack,
  output logic              Overrun
`endif
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  rx_state_t         state, next_state;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] next_word;
  logic              frame_done;

  assign next_word = {shift_reg[DATA_W-2:0], SDin};
  assign Busy      = (state == DATA);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    frame_done = 1'b0;
    case (state)
      IDLE: if (SDin == START_LEVEL) next_state = DATA;
      DATA: begin
        if (bit_cnt == LAST_BIT) begin
          next_state = IDLE;
          frame_done = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Counter restarts on every start bit so a frame never inherits a stale count.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (state == IDLE) begin
      if (SDin == START_LEVEL) bit_cnt <= '0;
    end else begin
      bit_cnt   <= bit_cnt + 1'b1;
      shift_reg <= next_word;
    end
  end

  serial_rx_holdreg #(
    .DATA_W (DATA_W)
  ) u_holdreg (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .load    (frame_done),
    .word    (next_word),
`ifdef SERIAL_RX_HANDSHAKE_EN
    .Ack     (Ack),
    .Overrun (Overrun),
`endif
    .PDout   (PDout),
    .Valid   (Valid)
  );

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard testbench for serial_rx; handshake cases run only when
// SERIAL_RX_HANDSHAKE_EN is defined.
module tb_serial_rx;

  logic       Clk;
  logic       Rst_n;
  logic       SDin;
  logic [7:0] PDout;
  logic       Valid;
  logic       Busy;
`ifdef SERIAL_RX_HANDSHAKE_EN
  logic       Ack;
  logic       Overrun;
`endif

  typedef struct {
    logic [7:0] word;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   busy_samples = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_pd = 8'h00;

  serial_rx #(.DATA_W(8)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .SDin    (SDin),
    .PDout   (PDout),
    .Valid   (Valid),
    .Busy    (Busy)
`ifdef SERIAL_RX_HANDSHAKE_EN
    ,
    .Ack     (Ack),
    .Overrun (Overrun)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every newly presented word is matched against the scoreboard.
  always @(negedge Clk) begin
    logic new_word;
    exp_t e;
    if (Rst_n) begin
      if (Busy) busy_samples++;
`ifdef SERIAL_RX_HANDSHAKE_EN
      new_word = Valid && (!prev_valid || PDout != prev_pd);
`else
      new_word = Valid;
`endif
      if (new_word) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_valid: got PDout=0x%0h, expected no word (cycle %0d)", PDout, cyc);
        end else begin
          e = sb.pop_front();
          check_output("word", int'(PDout), int'(e.word));
          check_output("valid_cycle", cyc, e.cyc);
        end
      end
      prev_valid = Valid;
      prev_pd    = PDout;
    end else begin
      prev_valid = 1'b0;
      prev_pd    = 8'h00;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge Clk);
      SDin = 1'b0;
`ifdef SERIAL_RX_HANDSHAKE_EN
      Ack = 1'b0;
`endif
    end
  endtask

  task automatic send_frame(input logic [7:0] w, input bit expect_it, input bit ack_last);
    exp_t e;
    @(negedge Clk);
    SDin = 1'b1;
    if (expect_it) begin
      e.word = w;
      e.cyc  = cyc + 1 + 8;
      sb.push_back(e);
    end
    for (int i = 7; i >= 0; i--) begin
      @(negedge Clk);
      SDin = w[i];
`ifdef SERIAL_RX_HANDSHAKE_EN
      Ack = (i == 0) ? ack_last : 1'b0;
`else
      if (ack_last && i == 0) $display("[TB] note: ack ignored in this build");
`endif
    end
  endtask

  // Behavioural stand-in for the transmitter: Send sampled at edge t,
  // start bit on the line from t+1, word visible after edge t+9.
  task automatic tx_send(input logic [7:0] w);
    exp_t e;
    @(negedge Clk);
    e.word = w;
    e.cyc  = cyc + 1 + 9;
    sb.push_back(e);
    @(negedge Clk);
    SDin = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      @(negedge Clk);
      SDin = w[i];
    end
  endtask

  task automatic reset_dut();
    @(negedge Clk);
    Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b0;
    SDin  = 1'b0;
    Rst_n = 1'b0;
`ifdef SERIAL_RX_HANDSHAKE_EN
    Ack = 1'b0;
`endif
    repeat (3) @(negedge Clk);
    check_output("reset_pdout", int'(PDout), 0);
    check_output("reset_valid", int'(Valid), 0);
    check_output("reset_busy", int'(Busy), 0);
`ifdef SERIAL_RX_HANDSHAKE_EN
    check_output("reset_overrun", int'(Overrun), 0);
`endif
    Rst_n = 1'b1;
    idle(2);

    b0 = busy_samples;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(12);
    check_output("busy_cycles", busy_samples - b0, 8);
    check_output("pdout_hold_a5", int'(PDout), 8'hA5);

    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(12);
    check_output("pdout_b2b", int'(PDout), 8'hC3);

    idle(50);
    send_frame(8'h00, 1'b1, 1'b0);
    idle(3);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(12);
    check_output("pdout_ff", int'(PDout), 8'hFF);
    check_output("busy_after_ff", int'(Busy), 0);

    // Abort a frame after its 4th data bit
    @(negedge Clk);
    SDin = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      SDin = 1'b1;
    end
    @(negedge Clk);
    Rst_n = 1'b0;
    SDin  = 1'b0;
    #1;
    check_output("midreset_pdout", int'(PDout), 0);
    check_output("midreset_valid", int'(Valid), 0);
    check_output("midreset_busy", int'(Busy), 0);
    @(negedge Clk);
    Rst_n = 1'b1;
    idle(2);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(12);
    check_output("pdout_81", int'(PDout), 8'h81);

    tx_send(8'h5A);
    idle(12);
    check_output("pdout_loop", int'(PDout), 8'h5A);

`ifdef SERIAL_RX_HANDSHAKE_EN
    reset_dut();
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    idle(3);
    check_output("hs_ovr_pdout", int'(PDout), 8'h11);
    check_output("hs_ovr_valid", int'(Valid), 1);
    check_output("hs_ovr_flag", int'(Overrun), 1);

    reset_dut();
    send_frame(8'h11, 1'b1, 1'b0);
    idle(2);
    send_frame(8'h22, 1'b1, 1'b1);
    idle(2);
    check_output("hs_ack_pdout", int'(PDout), 8'h22);
    check_output("hs_ack_valid", int'(Valid), 1);
    check_output("hs_ack_flag", int'(Overrun), 0);

    @(negedge Clk);
    Ack = 1'b1;
    @(negedge Clk);
    Ack = 1'b0;
    check_output("hs_clear_valid", int'(Valid), 0);
    check_output("hs_clear_pdout", int'(PDout), 8'h22);
`endif

    idle(12);
    check_output("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
